// File: rtl/bp_pkg.sv
`default_nettype none
// bp_pkg -- shared defaults, saturating-counter helpers and in-flight entry layout (rev 1.0)
package bp_pkg;

  localparam int BHT_ENTRIES_DEF = 512;
  localparam int CNT_W_DEF       = 2;
  localparam int Q_DEPTH_DEF     = 16;
  localparam int GSHARE_DEF      = 0;

  localparam int IDX_MAX   = 12;
  localparam int CNT_MAX_W = 4;

  // Sized for the largest table so one layout serves every parameter set
  typedef struct packed {
    logic [IDX_MAX-1:0] idx;
    logic               pred;
    logic [IDX_MAX-1:0] ghr;
  } bp_entry_t;

  localparam int ENTRY_W = $bits(bp_entry_t);

  function automatic logic [CNT_MAX_W-1:0] sat_inc(input logic [CNT_MAX_W-1:0] v,
                                                   input logic [CNT_MAX_W-1:0] top);
    return (v >= top) ? top : v + CNT_MAX_W'(1);
  endfunction

  function automatic logic [CNT_MAX_W-1:0] sat_dec(input logic [CNT_MAX_W-1:0] v);
    return (v == '0) ? v : v - CNT_MAX_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_queue.sv
`default_nettype none
// bp_queue -- circular FIFO of in-flight branches with synchronous flush (rev 1.0)
module bp_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = Q_DEPTH_DEF,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[head];
  // Full is sampled before any same-cycle pop, so a pop never frees a slot early
  assign do_push = en & push & ~full & ~flush;
  assign do_pop  = en & pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (en && flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_W'(1);
      if (do_pop)  head <= head + PTR_W'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// branch_predictor -- bimodal/gshare direction predictor with speculative and
// architectural history and an in-flight branch queue (rev 1.0)
module branch_predictor
  import bp_pkg::*;
#(
  parameter int BHT_ENTRIES = BHT_ENTRIES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int Q_DEPTH     = Q_DEPTH_DEF,
  parameter int GSHARE      = GSHARE_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rdy,
  input  logic [31:0]                lk_pc,
  output logic                       lk_taken,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic                       commit_valid,
  input  logic                       commit_taken,
  input  logic                       flush,
  output logic                       commit_mispred,
  output logic [$clog2(Q_DEPTH):0]   q_count,
  output logic                       err_underflow,
  output logic [31:0]                stat_branches,
  output logic [31:0]                stat_mispred
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CNT_MAX_W-1:0] CNT_TOP  = CNT_MAX_W'((1 << CNT_W) - 1);
  localparam logic [CNT_W-1:0]     CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [CNT_W-1:0]     pht [BHT_ENTRIES];
  logic [IDX_W-1:0]     spec_ghr;
  logic [IDX_W-1:0]     arch_ghr;
  logic [IDX_W-1:0]     arch_ghr_nxt;
  logic [IDX_W-1:0]     bim_idx;
  logic [IDX_W-1:0]     look_idx;
  logic [IDX_W-1:0]     upd_idx;
  logic [ENTRY_W-1:0]   head_raw;
  bp_entry_t            head_entry;
  bp_entry_t            push_entry;
  logic                 q_full;
  logic                 q_empty;
  logic                 do_push;
  logic                 do_commit;
  logic [CNT_MAX_W-1:0] ctr_cur;
  logic [CNT_MAX_W-1:0] ctr_new;
  logic                 unused_ok;

  assign bim_idx = lk_pc[IDX_W+1:2];

  generate
    if (GSHARE != 0) begin : g_gshare
      assign look_idx = bim_idx ^ spec_ghr;
    end else begin : g_bimodal
      assign look_idx = bim_idx;
    end
  endgenerate

  assign lk_taken   = pht[look_idx][CNT_W-1];
  assign push_ready = ~q_full;
  // Flush wins over a same-cycle push; the commit is still honoured
  assign do_push    = rdy & push_valid & ~q_full & ~flush;
  assign do_commit  = rdy & commit_valid & ~q_empty;

  assign head_entry     = bp_entry_t'(head_raw);
  assign upd_idx        = head_entry.idx[IDX_W-1:0];
  assign commit_mispred = commit_valid & ~q_empty & (head_entry.pred != commit_taken);

  always_comb begin
    push_entry                 = '0;
    push_entry.idx[IDX_W-1:0]  = look_idx;
    push_entry.pred            = lk_taken;
    push_entry.ghr[IDX_W-1:0]  = spec_ghr;
  end

  assign ctr_cur      = CNT_MAX_W'(pht[upd_idx]);
  assign ctr_new      = commit_taken ? sat_inc(ctr_cur, CNT_TOP) : sat_dec(ctr_cur);
  assign arch_ghr_nxt = do_commit ? {arch_ghr[IDX_W-2:0], commit_taken} : arch_ghr;

  bp_queue #(
    .DEPTH (Q_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rdy),
    .push  (do_push),
    .pop   (do_commit),
    .flush (flush),
    .din   (push_entry),
    .dout  (head_raw),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) pht[i] <= CNT_INIT;
    end else if (do_commit) begin
      pht[upd_idx] <= ctr_new[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_ghr      <= '0;
      arch_ghr      <= '0;
      err_underflow <= 1'b0;
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (rdy) begin
      arch_ghr <= arch_ghr_nxt;
      if (flush)        spec_ghr <= arch_ghr_nxt;
      else if (do_push) spec_ghr <= {spec_ghr[IDX_W-2:0], lk_taken};
      if (commit_valid && q_empty)   err_underflow <= 1'b1;
      if (do_commit)                 stat_branches <= stat_branches + 32'd1;
      if (do_commit && commit_mispred) stat_mispred <= stat_mispred + 32'd1;
    end
  end

  // Recorded history and upper PC bits are carried but not consumed here
  assign unused_ok = ^{lk_pc, head_raw, ctr_new};

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// tb_branch_predictor -- directed tables, hand sequences and a randomized run
// checked against an abstract reference model of the predictor.
module tb_branch_predictor;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rdy, push_valid, commit_valid, commit_taken, flush;
  logic [31:0] lk_pc;
  logic        lk_taken, push_ready, commit_mispred, err_underflow;
  logic [4:0]  q_count;
  logic [31:0] stat_branches, stat_mispred;

  logic        g_rdy;
  logic [31:0] g_pc;
  logic        g_pv, g_cv, g_ct, g_fl;
  logic        g_taken, g_ready, g_misp, g_err;
  logic [4:0]  g_qc;
  logic [31:0] g_sb, g_sm;

  branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .lk_pc(lk_pc), .lk_taken(lk_taken),
    .push_valid(push_valid), .push_ready(push_ready), .commit_valid(commit_valid),
    .commit_taken(commit_taken), .flush(flush), .commit_mispred(commit_mispred),
    .q_count(q_count), .err_underflow(err_underflow),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  branch_predictor #(.GSHARE(1)) dut_g (
    .clk(clk), .rst_n(rst_n), .rdy(g_rdy), .lk_pc(g_pc), .lk_taken(g_taken),
    .push_valid(g_pv), .push_ready(g_ready), .commit_valid(g_cv),
    .commit_taken(g_ct), .flush(g_fl), .commit_mispred(g_misp),
    .q_count(g_qc), .err_underflow(g_err),
    .stat_branches(g_sb), .stat_mispred(g_sm)
  );

  // Reference model: counters as plain integers, queue of in-flight records
  typedef struct { int idx; bit pred; } qent_t;
  qent_t       m_q[$];
  int          m_ctr[512];
  int          m_spec, m_arch;
  bit          m_err;
  int unsigned m_br, m_mp;

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_ctr[i]) m_ctr[i] = 1;
    m_q.delete();
    m_spec = 0; m_arch = 0; m_err = 0; m_br = 0; m_mp = 0;
  endtask

  task automatic check_model();
    int idx;
    bit pred, full, empty, misp;
    idx   = int'((lk_pc >> 2) & 32'd511);
    pred  = (m_ctr[idx] >= 2);
    full  = (m_q.size() == 16);
    empty = (m_q.size() == 0);
    misp  = commit_valid && !empty && (m_q[0].pred != commit_taken);
    chk("lk_taken", lk_taken, pred);
    chk("push_ready", push_ready, !full);
    chk("q_count", q_count, m_q.size());
    chk("commit_mispred", commit_mispred, misp);
    chk("err_underflow", err_underflow, m_err);
    chk("stat_branches", stat_branches, m_br);
    chk("stat_mispred", stat_mispred, m_mp);
    chk("spec_ghr", dut.spec_ghr, m_spec);
  endtask

  task automatic drive(bit r, logic [31:0] pc, bit pv, bit cv, bit ct, bit fl);
    rdy = r; lk_pc = pc; push_valid = pv; commit_valid = cv; commit_taken = ct; flush = fl;
    #1;
    check_model();
  endtask

  task automatic advance();
    int    idx;
    bit    pred, full;
    qent_t e;
    idx  = int'((lk_pc >> 2) & 32'd511);
    pred = (m_ctr[idx] >= 2);
    full = (m_q.size() == 16);
    if (rdy) begin
      if (commit_valid) begin
        if (m_q.size() == 0) m_err = 1;
        else begin
          e = m_q.pop_front();
          m_br++;
          if (e.pred != commit_taken) m_mp++;
          if (commit_taken) m_ctr[e.idx] = (m_ctr[e.idx] < 3) ? m_ctr[e.idx] + 1 : 3;
          else              m_ctr[e.idx] = (m_ctr[e.idx] > 0) ? m_ctr[e.idx] - 1 : 0;
          m_arch = ((m_arch << 1) | int'(commit_taken)) & 511;
        end
      end
      if (push_valid && !full && !flush) begin
        m_q.push_back('{idx, pred});
        m_spec = ((m_spec << 1) | int'(pred)) & 511;
      end
      if (flush) begin
        m_q.delete();
        m_spec = m_arch;
      end
    end
    @(negedge clk);
  endtask

  task automatic cycle(bit r, logic [31:0] pc, bit pv, bit cv, bit ct, bit fl);
    drive(r, pc, pv, cv, ct, fl);
    advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rdy = 1'b0; lk_pc = '0; push_valid = 1'b0; commit_valid = 1'b0;
    commit_taken = 1'b0; flush = 1'b0;
    g_pc = '0; g_pv = 1'b0; g_cv = 1'b0; g_ct = 1'b0; g_fl = 1'b0;
    #1;
    chk("rst_q_count", q_count, 0);
    chk("rst_push_ready", push_ready, 1);
    chk("rst_err", err_underflow, 0);
    chk("rst_stat_b", stat_branches, 0);
    chk("rst_stat_m", stat_mispred, 0);
    chk("rst_ctr", dut.pht[64], 1);
    chk("rst_arch_ghr", dut.arch_ghr, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] pc;
    bit pv, cv, ct;
    bit exp_taken;
    int exp_q;
    bit exp_misp;
  } vec_t;
  vec_t vt[6];

  bit gexp[3];

  initial begin
    vt[0] = '{32'h100, 0, 0, 0, 0, 0, 0};
    vt[1] = '{32'h100, 1, 0, 0, 0, 0, 0};
    vt[2] = '{32'h100, 1, 0, 0, 0, 1, 0};
    vt[3] = '{32'h100, 0, 1, 1, 0, 2, 1};
    vt[4] = '{32'h100, 0, 1, 1, 1, 1, 1};
    vt[5] = '{32'h100, 0, 0, 0, 1, 0, 0};
    gexp  = '{1, 1, 0};

    g_rdy = 1'b1;
    rst_n = 1'b0; rdy = 1'b0; lk_pc = '0; push_valid = 1'b0; commit_valid = 1'b0;
    commit_taken = 1'b0; flush = 1'b0;
    g_pc = '0; g_pv = 1'b0; g_cv = 1'b0; g_ct = 1'b0; g_fl = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Gshare history: train two entries, drain architectural history to zero
    g_pc = 32'h100; g_pv = 1; @(negedge clk);
    g_pc = 32'h104;           @(negedge clk);
    g_pv = 0; g_cv = 1; g_ct = 1; @(negedge clk);
    @(negedge clk);
    g_cv = 0; g_ct = 0;
    for (int i = 0; i < 9; i++) begin
      g_pc = 32'h200; g_pv = 1; g_cv = 0; @(negedge clk);
      g_pv = 0; g_cv = 1;                 @(negedge clk);
    end
    g_cv = 0;
    #1;
    chk("g_arch_zero", dut_g.arch_ghr, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      g_pc = 32'h100; g_pv = 1;
      #1;
      chk("g_pred", g_taken, gexp[i]);
      @(negedge clk);
    end
    g_pv = 0;
    #1;
    chk("g_spec_before_flush", dut_g.spec_ghr, 6);
    @(negedge clk);
    g_fl = 1; @(negedge clk);
    g_fl = 0;
    #1;
    chk("g_spec_after_flush", dut_g.spec_ghr, 0);
    chk("g_look_idx", dut_g.look_idx, 32'h40);
    chk("g_qc_after_flush", g_qc, 0);
    @(negedge clk);

    // Training of 0x100 from weakly not-taken
    do_reset();
    foreach (vt[i]) begin
      drive(1, vt[i].pc, vt[i].pv, vt[i].cv, vt[i].ct, 0);
      chk("vec_taken", lk_taken, vt[i].exp_taken);
      chk("vec_q_count", q_count, vt[i].exp_q);
      chk("vec_mispred", commit_mispred, vt[i].exp_misp);
      advance();
    end
    for (int i = 0; i < 3; i++) cycle(1, 32'h100, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 32'h100, 0, 1, 1, 0);
    drive(1, 32'h100, 0, 0, 0, 0);
    chk("sat_ctr", dut.pht[64], 3);
    advance();

    // Full queue behaviour
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1, 32'h100 + 32'(4 * i), 1, 0, 0, 0);
    drive(1, 32'h300, 1, 0, 0, 0);
    chk("full_ready", push_ready, 0);
    chk("full_count", q_count, 16);
    advance();
    drive(1, 32'h300, 0, 0, 0, 0);
    chk("after_17th", q_count, 16);
    advance();
    drive(1, 32'h300, 1, 1, 1, 0);
    chk("push_pop_full", q_count, 16);
    advance();
    drive(1, 32'h300, 0, 0, 0, 0);
    chk("blocked_push_at_full", q_count, 15);
    advance();

    // Flush with same-cycle commit
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 32'h100 + 32'(4 * i), 1, 0, 0, 0);
    cycle(1, 32'h500, 1, 1, 1, 1);
    drive(1, 32'h500, 0, 0, 0, 0);
    chk("flush_q_count", q_count, 0);
    chk("flush_head_ctr", dut.pht[64], 2);
    for (int i = 1; i < 5; i++) chk("flush_other_ctr", dut.pht[64 + i], 1);
    advance();

    // Underflow is sticky until reset
    do_reset();
    cycle(1, 32'h100, 0, 1, 1, 0);
    drive(1, 32'h100, 0, 0, 0, 0);
    chk("uf_err", err_underflow, 1);
    chk("uf_stat", stat_branches, 0);
    chk("uf_ctr", dut.pht[64], 1);
    advance();
    cycle(1, 32'h100, 1, 0, 0, 0);
    cycle(1, 32'h100, 0, 1, 1, 1);
    drive(1, 32'h100, 0, 0, 0, 0);
    chk("uf_sticky", err_underflow, 1);
    advance();
    do_reset();
    drive(1, 32'h100, 0, 0, 0, 0);
    chk("uf_cleared", err_underflow, 0);
    advance();

    // rdy low freezes everything
    for (int i = 0; i < 3; i++) cycle(1, 32'h100 + 32'(4 * i), 1, 0, 0, 0);
    cycle(1, 32'h100, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 32'h10c, 1, 1, 1, 0);
    drive(1, 32'h10c, 0, 0, 0, 0);
    chk("hold_q_count", q_count, 2);
    chk("hold_ctr0", dut.pht[64], 2);
    chk("hold_ctr1", dut.pht[65], 1);
    chk("hold_stat", stat_branches, 1);
    advance();

    // Randomized run with occasional mid-operation resets
    for (int n = 0; n < 600; n++) begin
      logic [31:0] pc;
      if ($urandom_range(0, 99) == 0) do_reset();
      pc = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'(4 * $urandom_range(0, 7)))
           | 32'($urandom_range(0, 3));
      cycle($urandom_range(0, 9) != 0, pc,
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
            $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
